// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared register-file widths and writeback entry type
package rv32i_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_hold_slot.sv
// rtl/wb_hold_slot.sv - one-entry writeback holding register with ready/accept/clear
module wb_hold_slot
  import rv32i_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] data,
  input  logic              grant,
  output logic              ready,
  output logic              held,
  output logic [ADDR_W-1:0] h_rd,
  output logic [DATA_W-1:0] h_data,
  output logic              load
);

  logic              held_q, held_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              accept;

  assign ready  = !held_q | grant;
  assign accept = valid & ready;
  // writes to x0 complete the handshake but never occupy the slot
  assign load   = accept & (rd != ADDR_W'(REG_ZERO));

  always_comb begin
    held_d = held_q;
    rd_d   = rd_q;
    data_d = data_q;
    if (grant) held_d = 1'b0;
    if (accept) begin
      held_d = load;
      rd_d   = rd;
      data_d = data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_q <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      held_q <= held_d;
      rd_q   <= rd_d;
      data_q <= data_d;
    end
  end

  assign held   = held_q;
  assign h_rd   = rd_q;
  assign h_data = data_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - ALU/load writeback arbiter for the register file write port
module regfile_wb_arbiter
  import rv32i_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              stall,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_reg_write,
  output logic              busy
);

  logic              alu_held, mem_held, alu_grant, mem_grant, alu_load, mem_load;
  logic [ADDR_W-1:0] alu_hrd, mem_hrd;
  logic [DATA_W-1:0] alu_hdata, mem_hdata;
  logic              rr_ptr_q, rr_ptr_d, mem_older_q, mem_older_d;
  wb_entry_t         win;

  wb_hold_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_alu_slot (
    .clk(clk), .rst(rst), .valid(alu_valid), .rd(alu_rd), .data(alu_data),
    .grant(alu_grant), .ready(alu_ready), .held(alu_held), .h_rd(alu_hrd),
    .h_data(alu_hdata), .load(alu_load)
  );

  wb_hold_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem_slot (
    .clk(clk), .rst(rst), .valid(mem_valid), .rd(mem_rd), .data(mem_data),
    .grant(mem_grant), .ready(mem_ready), .held(mem_held), .h_rd(mem_hrd),
    .h_data(mem_hdata), .load(mem_load)
  );

  always_comb begin
    alu_grant = alu_held;
    mem_grant = mem_held;
    if (alu_held && mem_held) begin
      // same destination must commit in program order, so age beats round-robin
      mem_grant = (alu_hrd == mem_hrd) ? mem_older_q : rr_ptr_q;
      alu_grant = !mem_grant;
    end
  end

  always_comb begin
    win = '0;
    if (alu_grant) win = '{valid: 1'b1, rd: alu_hrd, data: alu_hdata};
    else if (mem_grant) win = '{valid: 1'b1, rd: mem_hrd, data: mem_hdata};
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (alu_grant) rr_ptr_d = 1'b1;
    else if (mem_grant) rr_ptr_d = 1'b0;

    mem_older_d = mem_older_q;
    if (alu_load && mem_load) mem_older_d = 1'b1;
    else if (alu_load) mem_older_d = 1'b1;
    else if (mem_load) mem_older_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= 1'b0;
      mem_older_q <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      mem_older_q <= mem_older_d;
    end
  end

  assign rf_write     = win.valid;
  assign rf_rd        = win.rd;
  assign rf_reg_write = win.data;
  assign busy         = alu_held | mem_held;
  assign stall = ((rs1 != ADDR_W'(REG_ZERO)) &&
                  ((alu_held && rs1 == alu_hrd) || (mem_held && rs1 == mem_hrd))) ||
                 ((rs2 != ADDR_W'(REG_ZERO)) &&
                  ((alu_held && rs2 == alu_hrd) || (mem_held && rs2 == mem_hrd)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid, alu_ready, mem_ready;
  logic [4:0]  alu_rd, mem_rd, rs1, rs2, rf_rd;
  logic [31:0] alu_data, mem_data, rf_reg_write;
  logic        stall, rf_write, busy;

  int tests_run = 0;
  int tests_failed = 0;
  wb_entry_t exp_q[$];
  logic [31:0] regs [32];

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .rs1(rs1), .rs2(rs2), .stall(stall),
    .rf_write(rf_write), .rf_rd(rf_rd), .rf_reg_write(rf_reg_write), .busy(busy)
  );

  always @(posedge clk)
    if (!rst && rf_write && rf_rd != 5'd0) regs[rf_rd] <= rf_reg_write;

  always @(negedge clk) begin
    if (!rst && rf_write) begin
      wb_entry_t e;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h, expected no write", rf_rd, rf_reg_write);
      end else begin
        e = exp_q.pop_front();
        if (rf_rd !== e.rd || rf_reg_write !== e.data) begin
          tests_failed++;
          $display("FAIL wb_order: got rd=%0d data=%h, expected rd=%0d data=%h",
                   rf_rd, rf_reg_write, e.rd, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data);
    exp_q.push_back('{valid: 1'b1, rd: rd, data: data});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    rst = 1'b1;
    alu_valid = 0; mem_valid = 0; alu_rd = 0; mem_rd = 0;
    alu_data = 0; mem_data = 0; rs1 = 0; rs2 = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("reset_rf_write", rf_write, 0);
    chk("reset_rf_rd", rf_rd, 0);
    chk("reset_busy", busy, 0);
    chk("reset_alu_ready", alu_ready, 1);
    chk("reset_mem_ready", mem_ready, 1);
    rs1 = 5'd3;
    #1 chk("idle_stall", stall, 0);
    tick();
    chk("idle_rf_write", rf_write, 0);

    // single ALU write
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'hDEAD; push(5'd3, 32'hDEAD);
    tick();
    alu_valid = 0;
    #1;
    chk("alu_rf_write", rf_write, 1);
    chk("alu_stall_hit", stall, 1);
    chk("alu_busy", busy, 1);
    tick();
    chk("alu_stall_after", stall, 0);
    chk("alu_busy_after", busy, 0);
    chk("alu_x3", regs[3], 32'hDEAD);
    rs1 = 0;

    // different rd, simultaneous, from rr_ptr=0
    rst = 1; tick(); rst = 0;
    alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h11;
    mem_valid = 1; mem_rd = 5'd2; mem_data = 32'h22;
    push(5'd1, 32'h11); push(5'd2, 32'h22);
    tick();
    alu_valid = 0; mem_valid = 0; rs2 = 5'd2;
    #1;
    chk("diff_alu_ready", alu_ready, 1);
    chk("diff_mem_ready_wait", mem_ready, 0);
    chk("diff_stall_rs2", stall, 1);
    tick();
    chk("diff_mem_ready_grant", mem_ready, 1);
    chk("diff_alu_ready2", alu_ready, 1);
    tick();
    chk("diff_busy_after", busy, 0);
    chk("diff_mem_ready_idle", mem_ready, 1);
    chk("diff_x1", regs[1], 32'h11);
    chk("diff_x2", regs[2], 32'h22);
    rs2 = 0;

    // same rd: mem is older, must commit first even though rr favours ALU
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hBB;
    mem_valid = 1; mem_rd = 5'd5; mem_data = 32'hAA;
    push(5'd5, 32'hAA); push(5'd5, 32'hBB);
    tick();
    alu_valid = 0; mem_valid = 0;
    tick(); tick();
    chk("same_x5", regs[5], 32'hBB);
    chk("same_busy_after", busy, 0);

    // x0 drop
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'hFFFF;
    #1 chk("x0_alu_ready", alu_ready, 1);
    tick();
    alu_valid = 0;
    #1;
    chk("x0_busy", busy, 0);
    chk("x0_rf_write", rf_write, 0);
    tick();
    chk("x0_rf_write2", rf_write, 0);
    chk("x0_reg", regs[0], 0);

    // reset with both slots held
    alu_valid = 1; alu_rd = 5'd6; alu_data = 32'h66;
    mem_valid = 1; mem_rd = 5'd7; mem_data = 32'h77;
    tick();
    alu_valid = 0; mem_valid = 0; rst = 1;
    #1 chk("rst_mid_busy_before", busy, 1);
    tick();
    rst = 0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_rf_write", rf_write, 0);
    chk("rst_mid_rf_data", rf_reg_write, 0);
    tick();
    chk("rst_mid_rf_write2", rf_write, 0);
    chk("rst_mid_x6", regs[6], 0);
    chk("rst_mid_x7", regs[7], 0);

    tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
